// File: rtl/johnson_pkg.sv
// Shared types and helpers for logic that consumes a Johnson (twisted-ring) counter.
// Holds the lock FSM encoding, the index-to-code mapping and the phase index width.
package johnson_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_e;

  localparam int MAX_W = 32;

  // Index k of a width-bit Johnson sequence: fill with ones from the MSB, then drain them.
  function automatic logic [MAX_W-1:0] idx_to_code(input int k, input int width);
    logic [MAX_W-1:0] code;
    code = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width) begin
        if (k <= width) code[i] = (i >= width - k);
        else            code[i] = (i < 2 * width - k);
      end
    end
    return code;
  endfunction

  function automatic int phase_w(input int width);
    return (2 * width <= 2) ? 1 : $clog2(2 * width);
  endfunction

endpackage

// File: rtl/johnson_code_check.sv
// Combinational legality check and index decode of a Johnson code word.
// legal is 0 for any word outside the 2*WIDTH-entry sequence; idx is then 0.
module johnson_code_check
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]          code_in,
  output logic                      legal,
  output logic [phase_w(WIDTH)-1:0] idx
);

  localparam int N  = 2 * WIDTH;
  localparam int IW = phase_w(WIDTH);

  logic [N-1:0] match;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_match
      localparam logic [MAX_W-1:0] CODE = idx_to_code(gi, WIDTH);
      assign match[gi] = (code_in == CODE[WIDTH-1:0]);
    end
  endgenerate

  // Legal codes are distinct, so at most one match bit is ever set.
  always_comb begin
    legal = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (match[k]) begin
        legal = 1'b1;
        idx   = IW'(k);
      end
    end
  end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Decodes a sampled Johnson counter word into a registered one-hot phase and index,
// tracks sequence lock, flags illegal codes / sequence breaks and counts revolutions.
module johnson_phase_decoder
  import johnson_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int REV_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          code_in,
  input  logic                      code_vld,
  input  logic                      err_clr,
  output logic [2*WIDTH-1:0]        phase_onehot,
  output logic [phase_w(WIDTH)-1:0] phase_idx,
  output logic                      phase_vld,
  output logic                      locked,
  output logic                      err_pulse,
  output logic                      err_sticky,
  output logic [REV_W-1:0]          rev_cnt
);

  localparam int N  = 2 * WIDTH;
  localparam int IW = phase_w(WIDTH);
  localparam int RW = $clog2(N + 1);

  logic          chk_legal;
  logic [IW-1:0] chk_idx;

  johnson_code_check #(.WIDTH(WIDTH)) u_code_check (
    .code_in (code_in),
    .legal   (chk_legal),
    .idx     (chk_idx)
  );

  lock_state_e    state_q;
  logic [IW-1:0]  last_idx_q;
  logic [RW-1:0]  run_q;
  logic [N-1:0]   phase_onehot_q;
  logic [IW-1:0]  phase_idx_q;
  logic           phase_vld_q;
  logic           locked_q;
  logic           err_pulse_q;
  logic           err_sticky_q;
  logic [REV_W-1:0] rev_cnt_q;

  logic          last_is_top;
  logic [IW-1:0] succ_idx;
  logic [RW-1:0] run_inc;
  logic          step_good;
  logic          step_hold;
  logic          err_now;

  always_comb begin
    last_is_top = (last_idx_q == IW'(N - 1));
    succ_idx    = last_is_top ? '0 : last_idx_q + 1'b1;
    run_inc     = run_q + 1'b1;
    step_good   = (chk_idx == succ_idx);
    step_hold   = (chk_idx == last_idx_q);
    // Sequence breaks only count as errors once lock has been declared.
    err_now     = code_vld && (!chk_legal ||
                  (state_q == LOCKED && !step_good && !step_hold));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= UNLOCKED;
      last_idx_q     <= '0;
      run_q          <= '0;
      phase_onehot_q <= '0;
      phase_idx_q    <= '0;
      phase_vld_q    <= 1'b0;
      locked_q       <= 1'b0;
      err_pulse_q    <= 1'b0;
      err_sticky_q   <= 1'b0;
      rev_cnt_q      <= '0;
    end else begin
      phase_vld_q <= 1'b0;
      err_pulse_q <= err_now;
      if (err_now)      err_sticky_q <= 1'b1;
      else if (err_clr) err_sticky_q <= 1'b0;

      if (code_vld) begin
        if (!chk_legal) begin
          state_q  <= UNLOCKED;
          locked_q <= 1'b0;
        end else begin
          phase_onehot_q <= N'(1) << chk_idx;
          phase_idx_q    <= chk_idx;
          phase_vld_q    <= 1'b1;
          case (state_q)
            UNLOCKED: begin
              last_idx_q <= chk_idx;
              run_q      <= '0;
              state_q    <= LOCKING;
            end
            LOCKING: begin
              if (step_good) begin
                last_idx_q <= chk_idx;
                run_q      <= run_inc;
                if (run_inc >= RW'(LOCK_CNT)) begin
                  state_q  <= LOCKED;
                  locked_q <= 1'b1;
                end
              end else if (!step_hold) begin
                last_idx_q <= chk_idx;
                run_q      <= '0;
              end
            end
            LOCKED: begin
              if (step_good) begin
                last_idx_q <= chk_idx;
                if (last_is_top) rev_cnt_q <= rev_cnt_q + 1'b1;
              end else if (!step_hold) begin
                state_q    <= LOCKING;
                locked_q   <= 1'b0;
                last_idx_q <= chk_idx;
                run_q      <= '0;
              end
            end
            default: begin
              state_q  <= UNLOCKED;
              locked_q <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign phase_onehot = phase_onehot_q;
  assign phase_idx    = phase_idx_q;
  assign phase_vld    = phase_vld_q;
  assign locked       = locked_q;
  assign err_pulse    = err_pulse_q;
  assign err_sticky   = err_sticky_q;
  assign rev_cnt      = rev_cnt_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Scoreboard bench for johnson_phase_decoder (WIDTH=4, LOCK_CNT=2, REV_W=8): directed
// scenarios followed by randomized code streams, checked against a behavioural model.
module tb_johnson_phase_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] code_in;
  logic       code_vld;
  logic       err_clr;
  logic [7:0] phase_onehot;
  logic [2:0] phase_idx;
  logic       phase_vld;
  logic       locked;
  logic       err_pulse;
  logic       err_sticky;
  logic [7:0] rev_cnt;

  always #5 clk = ~clk;

  johnson_phase_decoder #(.WIDTH(4), .LOCK_CNT(2), .REV_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .code_in      (code_in),
    .code_vld     (code_vld),
    .err_clr      (err_clr),
    .phase_onehot (phase_onehot),
    .phase_idx    (phase_idx),
    .phase_vld    (phase_vld),
    .locked       (locked),
    .err_pulse    (err_pulse),
    .err_sticky   (err_sticky),
    .rev_cnt      (rev_cnt)
  );

  typedef struct {
    int onehot;
    int idx;
    int vld;
    int lck;
    int err;
    int sticky;
    int rev;
    int txn;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;
  int txn_no   = 0;

  // Behavioural model: sequence position, good-step count and flags as plain integers.
  int m_onehot, m_idx, m_sticky, m_rev, m_last, m_run;
  bit m_have, m_locked;

  function automatic int code_of(input int k);
    if (k <= 4) return ((1 << k) - 1) << (4 - k);
    return (1 << (8 - k)) - 1;
  endfunction

  function automatic int decode(input int code);
    for (int k = 0; k < 8; k++) if (code_of(k) == code) return k;
    return -1;
  endfunction

  task automatic step(input bit r, input bit v, input int code, input bit clr);
    exp_t e;
    int   k;
    rst      = r;
    code_vld = v;
    code_in  = code[3:0];
    err_clr  = clr;
    e.vld = 0;
    e.err = 0;
    if (r) begin
      m_onehot = 0; m_idx = 0; m_sticky = 0; m_rev = 0;
      m_last = 0; m_run = 0; m_have = 0; m_locked = 0;
    end else begin
      if (v) begin
        k = decode(code & 15);
        if (k < 0) begin
          e.err = 1; m_have = 0; m_locked = 0;
        end else begin
          m_onehot = 1 << k; m_idx = k; e.vld = 1;
          if (!m_have) begin
            m_have = 1; m_last = k; m_run = 0;
          end else if (k == (m_last + 1) % 8) begin
            if (m_locked && m_last == 7) m_rev = (m_rev + 1) % 256;
            m_last = k;
            if (!m_locked) begin
              m_run++;
              if (m_run >= 2) m_locked = 1;
            end
          end else if (k != m_last) begin
            if (m_locked) e.err = 1;
            m_locked = 0; m_last = k; m_run = 0;
          end
        end
      end
      if (e.err) m_sticky = 1;
      else if (clr) m_sticky = 0;
    end
    e.onehot = m_onehot; e.idx = m_idx; e.lck = int'(m_locked);
    e.sticky = m_sticky; e.rev = m_rev;
    e.txn = txn_no++;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input int k);
    step(0, 1, code_of(k % 8), 0);
  endtask

  task automatic chk(input string name, input int txn, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL txn=%0d %s actual=%0d required=%0d", txn, name, act, req);
    end
  endtask

  // Monitor: every clock edge that consumed a stimulus presents a response at the next negedge.
  initial begin
    int   n;
    exp_t e;
    forever begin
      @(posedge clk);
      n = exp_q.size();
      @(negedge clk);
      if (n > 0) begin
        e = exp_q.pop_front();
        chk("phase_onehot", e.txn, int'(phase_onehot), e.onehot);
        chk("phase_idx",    e.txn, int'(phase_idx),    e.idx);
        chk("phase_vld",    e.txn, int'(phase_vld),    e.vld);
        chk("locked",       e.txn, int'(locked),       e.lck);
        chk("err_pulse",    e.txn, int'(err_pulse),    e.err);
        chk("err_sticky",   e.txn, int'(err_sticky),   e.sticky);
        chk("rev_cnt",      e.txn, int'(rev_cnt),      e.rev);
        $display("txn %0d onehot=%b idx=%0d vld=%0d lck=%0d err=%0d sticky=%0d rev=%0d",
                 e.txn, phase_onehot, phase_idx, phase_vld, locked, err_pulse,
                 err_sticky, rev_cnt);
      end
    end
  end

  initial begin
    int cur, r, c;
    rst = 1'b1; code_vld = 1'b0; code_in = '0; err_clr = 1'b0;

    // Lock on 0000, 1000, 1100.
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    smp(0); smp(1); smp(2);

    // 17 in-order samples from 0000: two revolutions.
    step(1, 0, 0, 0);
    for (int i = 0; i < 17; i++) smp(i);

    // Illegal code while locked at 1110, then re-enter at 0111.
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) smp(i);
    step(0, 1, 4'b1010, 0);
    smp(5);

    // Skip 1100 -> 1111, then relock with 0111, 0011.
    step(1, 0, 0, 0);
    smp(0); smp(1); smp(2); smp(4); smp(5); smp(6);

    // Stall at 1110, then repeated holds.
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) smp(i);
    for (int i = 0; i < 5; i++) step(0, 0, $urandom_range(0, 15), 0);
    smp(3); smp(3); smp(3);

    // err_clr racing an illegal code, err_clr alone, reset with rev_cnt=3.
    step(0, 1, 4'b0101, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    for (int i = 0; i < 25; i++) smp(i);
    step(1, 1, code_of(1), 0);
    step(0, 0, 0, 0);

    // Randomized stream: mostly in-order with holds, skips, illegal codes, stalls, clears.
    cur = 0;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60) begin
        cur = (cur + 1) % 8;
        step(0, 1, code_of(cur), $urandom_range(0, 19) == 0);
      end else if (r < 70) begin
        step(0, 1, code_of(cur), $urandom_range(0, 19) == 0);
      end else if (r < 76) begin
        cur = $urandom_range(0, 7);
        step(0, 1, code_of(cur), 0);
      end else if (r < 82) begin
        do c = $urandom_range(0, 15); while (decode(c) >= 0);
        step(0, 1, c, $urandom_range(0, 1));
      end else if (r < 92) begin
        step(0, 0, $urandom_range(0, 15), 0);
      end else if (r < 99) begin
        step(0, $urandom_range(0, 1), code_of(cur), 1);
      end else begin
        step(1, 1, code_of(cur), 0);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", txn_no, exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
